// File: rtl/fwd_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// fwd_hazard_ctrl
//   Forwarding and hazard control for the 5-stage core. Keeps a shadow copy
//   of the register tags travelling through EX, MEM and WB so the datapath
//   only supplies ID-stage decode information. Drives the EX operand
//   forwarding selects, the load-use stall and the branch flush, and keeps
//   saturating performance counters for stall and forward cycles.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   id_valid          ID holds a real instruction
//   id_rs, id_rt      ID source registers
//   id_uses_rs/_rt    ID instruction actually reads rs / rt
//   id_rd             ID destination (after RegDst)
//   id_regwrite       ID instruction writes the register file
//   id_memread        ID instruction is a load
//   id_branch_taken   branch resolved taken in ID
//   src1, src2        EX operand selects: 00 reg file, 01 MEM, 10 WB
//   stall             hold PC and IF/ID, bubble into ID/EX
//   flush             zero IF/ID
//   stall_count       saturating count of stall cycles
//   fwd_count         saturating count of cycles with any forwarding
// ---------------------------------------------------------------------------
module fwd_hazard_ctrl #(
    parameter int REG_W   = 5,
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               id_valid,
    input  logic [REG_W-1:0]   id_rs,
    input  logic [REG_W-1:0]   id_rt,
    input  logic               id_uses_rs,
    input  logic               id_uses_rt,
    input  logic [REG_W-1:0]   id_rd,
    input  logic               id_regwrite,
    input  logic               id_memread,
    input  logic               id_branch_taken,
    output logic [1:0]         src1,
    output logic [1:0]         src2,
    output logic               stall,
    output logic               flush,
    output logic [COUNT_W-1:0] stall_count,
    output logic [COUNT_W-1:0] fwd_count
);

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rs;
        logic [REG_W-1:0] rt;
        logic [REG_W-1:0] rd;
        logic             regwrite;
        logic             memread;
    } stage_t;

    stage_t ex_p1;
    stage_t mem_p2;
    stage_t wb_p3;
    stage_t id_rec;
    logic   fwd_any;

    // WB source/load fields are carried only to keep the record uniform.
    logic unused_wb;
    assign unused_wb = ^{wb_p3.rs, wb_p3.rt, wb_p3.memread};

    // Register 0 is hardwired, so it never acts as a producer.
    function automatic logic is_writer(input stage_t s);
        return s.valid && s.regwrite && (s.rd != '0);
    endfunction

    // MEM is checked first: it holds the younger, more recent value.
    function automatic logic [1:0] fwd_sel(input logic ex_valid,
                                           input logic [REG_W-1:0] src,
                                           input stage_t mem_s,
                                           input stage_t wb_s);
        if (!ex_valid)
            return 2'b00;
        if (is_writer(mem_s) && (mem_s.rd == src))
            return 2'b01;
        if (is_writer(wb_s) && (wb_s.rd == src))
            return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] c,
                                                   input logic en);
        if (en && (c != {COUNT_W{1'b1}}))
            return c + COUNT_W'(1);
        return c;
    endfunction

    // Outputs are held idle during reset so stale state cannot leak a hazard.
    always_comb begin
        src1  = 2'b00;
        src2  = 2'b00;
        stall = 1'b0;
        if (!rst) begin
            src1  = fwd_sel(ex_p1.valid, ex_p1.rs, mem_p2, wb_p3);
            src2  = fwd_sel(ex_p1.valid, ex_p1.rt, mem_p2, wb_p3);
            stall = ex_p1.valid && ex_p1.memread && (ex_p1.rd != '0) && id_valid &&
                    ((id_uses_rs && (ex_p1.rd == id_rs)) ||
                     (id_uses_rt && (ex_p1.rd == id_rt)));
        end
        flush   = id_branch_taken && id_valid && !stall;
        fwd_any = (src1 != 2'b00) || (src2 != 2'b00);
    end

    // ID decode record; a stalled or empty ID slot becomes a bubble.
    always_comb begin
        id_rec = '0;
        if (id_valid && !stall) begin
            id_rec.valid    = 1'b1;
            id_rec.rs       = id_rs;
            id_rec.rt       = id_rt;
            id_rec.rd       = id_rd;
            id_rec.regwrite = id_regwrite;
            id_rec.memread  = id_memread;
        end
    end

    // ID -> EX (p1) -> MEM (p2) -> WB (p3)
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_p1       <= '0;
            mem_p2      <= '0;
            wb_p3       <= '0;
            stall_count <= '0;
            fwd_count   <= '0;
        end else begin
            wb_p3       <= mem_p2;
            mem_p2      <= ex_p1;
            ex_p1       <= id_rec;
            stall_count <= sat_inc(stall_count, stall);
            fwd_count   <= sat_inc(fwd_count, fwd_any);
        end
    end

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
module tb_fwd_hazard_ctrl;
    localparam int REG_W   = 5;
    localparam int COUNT_W = 4;
    localparam int CMAX    = (1 << COUNT_W) - 1;

    logic               clk = 1'b0;
    logic               rst;
    logic               id_valid;
    logic [REG_W-1:0]   id_rs;
    logic [REG_W-1:0]   id_rt;
    logic               id_uses_rs;
    logic               id_uses_rt;
    logic [REG_W-1:0]   id_rd;
    logic               id_regwrite;
    logic               id_memread;
    logic               id_branch_taken;
    logic [1:0]         src1;
    logic [1:0]         src2;
    logic               stall;
    logic               flush;
    logic [COUNT_W-1:0] stall_count;
    logic [COUNT_W-1:0] fwd_count;

    fwd_hazard_ctrl #(.REG_W(REG_W), .COUNT_W(COUNT_W)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread),
        .id_branch_taken(id_branch_taken),
        .src1(src1), .src2(src2), .stall(stall), .flush(flush),
        .stall_count(stall_count), .fwd_count(fwd_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: in-flight instructions indexed by age in stages past
    // ID (0 = EX, 1 = MEM, 2 = WB). The forwarding select equals the age
    // distance of the nearest older producer.
    typedef struct {
        bit valid;
        int rs, rt, rd;
        bit rw, mr;
    } ins_t;
    ins_t pipe[3];
    int m_stall = 0;
    int m_fwd   = 0;

    function automatic ins_t bubble();
        ins_t b;
        b.valid = 0; b.rs = 0; b.rt = 0; b.rd = 0; b.rw = 0; b.mr = 0;
        return b;
    endfunction

    function automatic int exp_sel(int r);
        if (rst || !pipe[0].valid) return 0;
        for (int k = 1; k <= 2; k++)
            if (pipe[k].valid && pipe[k].rw && pipe[k].rd != 0 && pipe[k].rd == r)
                return k;
        return 0;
    endfunction

    function automatic bit exp_stall();
        if (rst) return 0;
        if (!(pipe[0].valid && pipe[0].mr && pipe[0].rd != 0 && id_valid)) return 0;
        return (id_uses_rs && pipe[0].rd == int'(id_rs)) ||
               (id_uses_rt && pipe[0].rd == int'(id_rt));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_id(input bit v, input int rs, input int rt, input bit urs,
                          input bit urt, input int rd, input bit rw, input bit mr,
                          input bit br);
        id_valid = v; id_rs = rs[REG_W-1:0]; id_rt = rt[REG_W-1:0];
        id_uses_rs = urs; id_uses_rt = urt; id_rd = rd[REG_W-1:0];
        id_regwrite = rw; id_memread = mr; id_branch_taken = br;
    endtask

    task automatic idle();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Check all outputs against the model, then advance one clock.
    task automatic cycle();
        int e1, e2;
        bit es, ef;
        ins_t n;
        #1;
        e1 = exp_sel(pipe[0].rs);
        e2 = exp_sel(pipe[0].rt);
        es = exp_stall();
        ef = id_branch_taken && id_valid && !es;
        chk("src1", src1, e1);
        chk("src2", src2, e2);
        chk("stall", stall, es);
        chk("flush", flush, ef);
        chk("stall_count", stall_count, m_stall);
        chk("fwd_count", fwd_count, m_fwd);
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 3; i++) pipe[i] = bubble();
            m_stall = 0;
            m_fwd   = 0;
        end else begin
            if (es && m_stall < CMAX) m_stall++;
            if ((e1 != 0 || e2 != 0) && m_fwd < CMAX) m_fwd++;
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            n = bubble();
            if (id_valid && !es) begin
                n.valid = 1; n.rs = int'(id_rs); n.rt = int'(id_rt); n.rd = int'(id_rd);
                n.rw = id_regwrite; n.mr = id_memread;
            end
            pipe[0] = n;
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1;
        idle();
        cycle();
        rst = 0;
    endtask

    initial begin
        for (int i = 0; i < 3; i++) pipe[i] = bubble();
        rst = 1;
        idle();
        @(posedge clk);
        #1;

        // Reset held with a load present in ID
        set_id(1, 5, 0, 1, 0, 5, 1, 1, 0);
        repeat (3) cycle();
        #1;
        chk("t1_stall_in_rst", stall, 0);
        chk("t1_cnt_in_rst", stall_count, 0);
        rst = 0;
        #1;
        chk("t1_no_stall_after_rst", stall, 0);
        cycle();
        cycle();
        #1;
        chk("t1_stall_count", stall_count, 1);

        // Back-to-back ALU dependency: MEM forward
        do_reset();
        set_id(1, 0, 0, 0, 0, 3, 1, 0, 0); cycle();
        set_id(1, 3, 0, 1, 0, 9, 1, 0, 0); cycle();
        idle();
        #1; chk("t2_src1_mem", src1, 2'b01);
        cycle();
        // One independent op between: WB forward
        do_reset();
        set_id(1, 0, 0, 0, 0, 3, 1, 0, 0); cycle();
        set_id(1, 1, 2, 1, 1, 10, 1, 0, 0); cycle();
        set_id(1, 3, 0, 1, 0, 9, 1, 0, 0); cycle();
        idle();
        #1; chk("t2_src1_wb", src1, 2'b10);
        cycle();
        // Producer writes r0: no forward
        do_reset();
        set_id(1, 0, 0, 0, 0, 0, 1, 0, 0); cycle();
        set_id(1, 0, 0, 1, 0, 9, 1, 0, 0); cycle();
        idle();
        #1; chk("t2_src1_r0", src1, 2'b00);
        cycle();

        // Load-use: one stall, then WB forward
        do_reset();
        set_id(1, 0, 0, 0, 0, 4, 1, 1, 0); cycle();
        set_id(1, 0, 4, 0, 1, 6, 1, 0, 0);
        #1; chk("t3_stall", stall, 1);
        cycle();
        #1; chk("t3_stall_once", stall, 0);
        cycle();
        idle();
        #1; chk("t3_src2_wb", src2, 2'b10);
        cycle();
        #1;
        chk("t3_stall_count", stall_count, 1);
        chk("t3_fwd_count", fwd_count, 1);

        // Double hazard: MEM and WB both write r7
        do_reset();
        set_id(1, 0, 0, 0, 0, 7, 1, 0, 0); cycle();
        set_id(1, 0, 0, 0, 0, 7, 1, 0, 0); cycle();
        set_id(1, 7, 7, 1, 1, 8, 1, 0, 0); cycle();
        idle();
        #1;
        chk("t4_src1", src1, 2'b01);
        chk("t4_src2", src2, 2'b01);
        cycle();
        #1; chk("t4_fwd_count", fwd_count, 1);

        // Branch flush, alone and against a load-use stall
        do_reset();
        set_id(1, 0, 0, 0, 0, 0, 0, 0, 1);
        #1; chk("t5_flush", flush, 1);
        cycle();
        idle();
        #1; chk("t5_flush_off", flush, 0);
        cycle();
        set_id(1, 0, 0, 0, 0, 4, 1, 1, 0); cycle();
        set_id(1, 4, 0, 1, 0, 0, 0, 0, 1);
        #1;
        chk("t5_stall_br", stall, 1);
        chk("t5_flush_blocked", flush, 0);
        cycle();
        #1; chk("t5_flush_late", flush, 1);
        cycle();
        idle(); cycle();

        // Counter saturation with a self-dependent load held in ID
        do_reset();
        set_id(1, 4, 0, 1, 0, 4, 1, 1, 0);
        repeat (40) cycle();
        #1; chk("t6_sat", stall_count, CMAX);
        idle();
        repeat (3) cycle();
        #1; chk("t6_sat_hold", stall_count, CMAX);

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 800; i++) begin
            rst = ($urandom_range(0, 59) == 0);
            set_id($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
                   $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 7),
                   $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                   $urandom_range(0, 5) == 0);
            cycle();
        end
        rst = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
